// File: rtl/mem_bus_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_bus_pkg
// Brief    : Shared types and constants for the two-port AXI4-Lite arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter2
// Brief    : Two-way combinational grant, fixed or round-robin, with the
//            last-granted register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mode,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_grant_idx,
    output logic       o_grant_any
);

    logic r_rr_last;

    always_comb begin
        o_grant_any = |i_req;
        o_grant_idx = 1'b0;
        case (i_req)
            2'b10:   o_grant_idx = 1'b1;
            2'b11:   o_grant_idx = i_mode ? ~r_rr_last : 1'b0;
            default: o_grant_idx = 1'b0;
        endcase
    end

    // Reset to 1 so port 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (i_update && o_grant_any) begin
            r_rr_last <= o_grant_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_bus_arbiter
// Brief    : Shares one AXI4-Lite master port between the data and fetch
//            requesters, one transaction at a time.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_we,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    input  logic [1:0][3:0]  req_wstrb,
    output logic [1:0]       resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [1:0]       busy,
    output logic             timeout,
    output logic             awvalid,
    output logic [31:0]      awaddr,
    input  logic             awready,
    output logic             wvalid,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    input  logic             wready,
    input  logic             bvalid,
    input  logic [1:0]       bresp,
    output logic             bready,
    output logic             arvalid,
    output logic [31:0]      araddr,
    input  logic             arready,
    input  logic             rvalid,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    output logic             rready
);

    localparam logic [31:0] c_timeout = 32'(TIMEOUT);

    arb_state_t  r_state;
    mem_req_t    r_req;
    logic        r_grant;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_tcnt;

    mem_req_t    w_sel_req;
    logic        w_gidx;
    logic        w_gany;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_leave;
    logic        w_wait;
    logic [1:0]  w_onehot;
    logic        w_unused;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (ARB_MODE != 0),
        .i_req       (req_valid),
        .i_update    (r_state == ST_IDLE),
        .o_grant_idx (w_gidx),
        .o_grant_any (w_gany)
    );

    always_comb begin
        w_sel_req.we    = req_we[w_gidx];
        w_sel_req.addr  = req_addr[w_gidx];
        w_sel_req.wdata = req_wdata[w_gidx];
        w_sel_req.wstrb = req_wstrb[w_gidx];
    end

    assign awaddr   = r_req.addr;
    assign araddr   = r_req.addr;
    assign wdata    = r_req.wdata;
    assign wstrb    = r_req.wstrb;
    assign busy     = req_valid & ~resp_valid;
    assign w_onehot = r_grant ? 2'b10 : 2'b01;
    assign w_aw_fin = r_aw_done | (awvalid & awready);
    assign w_w_fin  = r_w_done | (wvalid & wready);
    assign w_unused = &{1'b0, bresp[0], rresp[0]};

    always_comb begin
        w_leave = 1'b0;
        w_wait  = 1'b0;
        case (r_state)
            ST_WR_ADDR: begin w_leave = w_aw_fin & w_w_fin;  w_wait = ~w_leave; end
            ST_WR_RESP: begin w_leave = bvalid & bready;     w_wait = ~w_leave; end
            ST_RD_ADDR: begin w_leave = arvalid & arready;   w_wait = ~w_leave; end
            ST_RD_DATA: begin w_leave = rvalid & rready;     w_wait = ~w_leave; end
            default:    begin w_leave = 1'b0;                w_wait = 1'b0;     end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_grant    <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_tcnt     <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            timeout    <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
        end else begin
            resp_valid <= '0;

            // Any state change clears the count; it never wraps once at the limit.
            if (w_wait) begin
                if (r_tcnt != c_timeout) r_tcnt <= r_tcnt + 32'd1;
                if (c_timeout != '0 && r_tcnt + 32'd1 == c_timeout) timeout <= 1'b1;
            end else begin
                r_tcnt <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_gany) begin
                        r_grant   <= w_gidx;
                        r_req     <= w_sel_req;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (w_sel_req.we) begin
                            r_state <= ST_WR_ADDR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            r_state <= ST_RD_ADDR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (awvalid && awready) begin
                        awvalid   <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid   <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_leave) begin
                        r_state <= ST_WR_RESP;
                        bready  <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (w_leave) begin
                        bready     <= 1'b0;
                        resp_err   <= bresp[1];
                        resp_rdata <= '0;
                        resp_valid <= w_onehot;
                        r_state    <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (w_leave) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (w_leave) begin
                        rready     <= 1'b0;
                        resp_rdata <= rdata;
                        resp_err   <= rresp[1];
                        resp_valid <= w_onehot;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
